// File: rtl/isp_pkg.sv
// rtl/isp_pkg.sv - shared ISP state encoding and default frame geometry
package isp_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_LINE = 2'd2;
   localparam logic [1:0] S_END  = 2'd3;

   localparam int DEF_IMG_W = 640;
   localparam int DEF_IMG_H = 480;
   localparam int DEF_CNT_W = 11;
   localparam int DEF_DLY   = 1;

endpackage

// File: rtl/sig_delay_line.sv
// rtl/sig_delay_line.sv - fixed-depth register pipeline with async active-low clear
module sig_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/line_buf_window_ctrl.sv
// rtl/line_buf_window_ctrl.sv - column/row sequencer and sync alignment for a 2-line 3x3 line buffer
module line_buf_window_ctrl
   import isp_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int CNT_W = DEF_CNT_W,
   parameter int DLY   = DEF_DLY
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             per_frame_vsync,
   input  logic             per_frame_href,
   input  logic             per_frame_clken,
   output logic             lb_clken,
   output logic             lb_href,
   output logic             post_frame_vsync,
   output logic             post_frame_href,
   output logic             post_frame_clken,
   output logic [CNT_W-1:0] col_cnt,
   output logic [CNT_W-1:0] row_cnt,
   output logic             win_valid,
   output logic             line_err,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] COL_MAX  = '1;
   localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] WIN_MIN  = CNT_W'(2);
   localparam int               PIPE_W   = 3 + 2 * CNT_W;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] col, col_nxt;
   logic [CNT_W-1:0] row, row_nxt;
   logic [CNT_W-1:0] cur_col;
   logic             vsync_d, href_d;
   logic             vsync_rise, href_rise, href_fall;
   logic             frame_act;
   logic [PIPE_W-1:0] pipe_in, pipe_out;

   assign vsync_rise = per_frame_vsync & ~vsync_d;
   assign href_rise  = per_frame_href & ~href_d;
   assign href_fall  = ~per_frame_href & href_d;
   assign frame_act  = (state != S_IDLE);

   // Buffer strobes bypass all registers so they line up with the pixel data.
   assign lb_clken = per_frame_clken & per_frame_href & frame_act;
   assign lb_href  = per_frame_href & frame_act;

   // The pixel arriving with href rise is column 0 while col still holds the old line.
   assign cur_col = (state == S_LINE) ? col : '0;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d <= 1'b0;
         href_d  <= 1'b0;
         state   <= S_IDLE;
         col     <= '0;
         row     <= '0;
      end else begin
         vsync_d <= per_frame_vsync;
         href_d  <= per_frame_href;
         state   <= state_nxt;
         col     <= col_nxt;
         row     <= row_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      case (state)
         S_IDLE: begin
            if (vsync_rise) begin
               state_nxt = S_WAIT;
               row_nxt   = '0;
            end
         end
         S_WAIT: begin
            if (vsync_rise) begin
               row_nxt = '0;
            end else if (href_rise) begin
               state_nxt = S_LINE;
               col_nxt   = per_frame_clken ? CNT_W'(1) : '0;
            end
         end
         S_LINE: begin
            // A new frame aborts the line without reporting a length error.
            if (vsync_rise) begin
               state_nxt = S_WAIT;
               row_nxt   = '0;
            end else if (href_fall) begin
               state_nxt = S_END;
            end else if (per_frame_clken && per_frame_href && col != COL_MAX) begin
               col_nxt = col + CNT_W'(1);
            end
         end
         S_END: begin
            if (vsync_rise) begin
               state_nxt = S_WAIT;
               row_nxt   = '0;
            end else if (row == LAST_ROW) begin
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_WAIT;
               row_nxt   = row + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign line_err   = (state == S_END) && (col != LINE_LEN);
   assign frame_done = (state == S_END) && (row == LAST_ROW);

   assign pipe_in = {per_frame_vsync, per_frame_href, lb_clken, row, cur_col};

   sig_delay_line #(
      .WIDTH (PIPE_W),
      .DEPTH (DLY)
   ) u_sync_dly (
      .clock (clock),
      .rst_n (rst_n),
      .din   (pipe_in),
      .dout  (pipe_out)
   );

   assign {post_frame_vsync, post_frame_href, post_frame_clken, row_cnt, col_cnt} = pipe_out;

   assign win_valid = post_frame_clken && (row_cnt >= WIN_MIN) && (col_cnt >= WIN_MIN);

endmodule

// File: tb/tb_line_buf_window_ctrl.sv
// tb/tb_line_buf_window_ctrl.sv - scoreboard bench for line_buf_window_ctrl on a 4x3 frame
module tb_line_buf_window_ctrl;

   localparam int IMG_W = 4;
   localparam int IMG_H = 3;
   localparam int CNT_W = 11;
   localparam int DLY   = 1;

   logic             clock = 1'b0;
   logic             rst_n;
   logic             per_frame_vsync, per_frame_href, per_frame_clken;
   logic             lb_clken, lb_href;
   logic             post_frame_vsync, post_frame_href, post_frame_clken;
   logic [CNT_W-1:0] col_cnt, row_cnt;
   logic             win_valid, line_err, frame_done;

   typedef struct {int row; int col; int win;} pix_t;
   pix_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int win_cnt = 0, err_cnt = 0, done_cnt = 0;
   int err_cyc = -1, done_cyc = -1;
   bit prev_vs, prev_hr, prev_lb;

   line_buf_window_ctrl #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .CNT_W (CNT_W),
      .DLY   (DLY)
   ) dut (
      .clock            (clock),
      .rst_n            (rst_n),
      .per_frame_vsync  (per_frame_vsync),
      .per_frame_href   (per_frame_href),
      .per_frame_clken  (per_frame_clken),
      .lb_clken         (lb_clken),
      .lb_href          (lb_href),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_href  (post_frame_href),
      .post_frame_clken (post_frame_clken),
      .col_cnt          (col_cnt),
      .row_cnt          (row_cnt),
      .win_valid        (win_valid),
      .line_err         (line_err),
      .frame_done       (frame_done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (!rst_n) begin
         prev_vs = 1'b0;
         prev_hr = 1'b0;
         prev_lb = 1'b0;
         sb.delete();
      end else begin
         chk("post_vsync", post_frame_vsync, prev_vs);
         chk("post_href", post_frame_href, prev_hr);
         chk("post_clken", post_frame_clken, prev_lb);
         if (post_frame_clken) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               pix_t e;
               e = sb.pop_front();
               chk("col_cnt", int'(col_cnt), e.col);
               chk("row_cnt", int'(row_cnt), e.row);
               chk("win_valid", win_valid, e.win);
            end
         end else begin
            chk("win_idle", win_valid, 0);
         end
         if (win_valid) win_cnt++;
         if (line_err) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_vs = per_frame_vsync;
         prev_hr = per_frame_href;
         prev_lb = lb_clken;
      end
   end

   task automatic tick(input bit vs, input bit hr, input bit ck, input bit act);
      @(posedge clock);
      #1;
      per_frame_vsync = vs;
      per_frame_href  = hr;
      per_frame_clken = ck;
      #1;
      chk("lb_clken", lb_clken, int'(ck & hr & act));
      chk("lb_href", lb_href, int'(hr & act));
   endtask

   task automatic start_frame();
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic send_line(input int npix, input bit gap, input int row, input bit act,
                            output int fall);
      for (int p = 0; p < npix; p++) begin
         tick(1'b0, 1'b1, 1'b1, act);
         if (act) sb.push_back('{row, p, int'(row >= 2 && p >= 2)});
         if (gap && p < npix - 1) tick(1'b0, 1'b1, 1'b0, act);
      end
      tick(1'b0, 1'b0, 1'b0, act);
      fall = cyc;
      tick(1'b0, 1'b0, 1'b0, act);
      tick(1'b0, 1'b0, 1'b0, act);
   endtask

   initial begin
      int fall;
      rst_n = 1'b0;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      #2;
      chk("rst_flags", int'({lb_clken, lb_href, post_frame_vsync, post_frame_href,
                             post_frame_clken, win_valid, line_err, frame_done}), 0);
      chk("rst_col", int'(col_cnt), 0);
      chk("rst_row", int'(row_cnt), 0);
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;

      // full 4x3 frame: window valid only at row 2, cols 2 and 3
      start_frame();
      for (int r = 0; r < IMG_H; r++) send_line(IMG_W, 1'b0, r, 1'b1, fall);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_done_lat", done_cyc - fall, 1);
      chk("t1_win_cnt", win_cnt, 2);
      chk("t1_err_cnt", err_cnt, 0);

      // extra line after frame_done is ignored
      send_line(IMG_W, 1'b0, 0, 1'b0, fall);
      chk("t6_err_cnt", err_cnt, 0);
      chk("t6_done_cnt", done_cnt, 1);
      chk("t6_row", int'(row_cnt), IMG_H - 1);
      chk("t6_sb_empty", sb.size(), 0);

      // short middle line flags line_err and the row still advances
      start_frame();
      send_line(IMG_W, 1'b0, 0, 1'b1, fall);
      send_line(IMG_W - 1, 1'b0, 1, 1'b1, fall);
      chk("t2_err_cnt", err_cnt, 1);
      chk("t2_err_lat", err_cyc - fall, 1);
      send_line(IMG_W, 1'b0, 2, 1'b1, fall);
      chk("t2_done_cnt", done_cnt, 2);
      chk("t2_err_after", err_cnt, 1);

      // clken toggling inside href
      start_frame();
      for (int r = 0; r < IMG_H; r++) send_line(IMG_W, 1'b1, r, 1'b1, fall);
      chk("t3_err_cnt", err_cnt, 1);
      chk("t3_done_cnt", done_cnt, 3);

      // vsync rise mid-line at row 1, col 2 aborts cleanly
      start_frame();
      send_line(IMG_W, 1'b0, 0, 1'b1, fall);
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      sb.push_back('{1, 0, 0});
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      sb.push_back('{1, 1, 0});
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4_err_cnt", err_cnt, 1);
      for (int r = 0; r < IMG_H; r++) send_line(IMG_W, 1'b0, r, 1'b1, fall);
      chk("t4_err_after", err_cnt, 1);
      chk("t4_done_cnt", done_cnt, 4);

      // reset pulse during row 1
      start_frame();
      send_line(IMG_W, 1'b0, 0, 1'b1, fall);
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      sb.push_back('{1, 0, 0});
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      sb.push_back('{1, 1, 0});
      @(posedge clock);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_flags", int'({lb_clken, lb_href, post_frame_vsync, post_frame_href,
                            post_frame_clken, win_valid, line_err, frame_done}), 0);
      chk("t5_col", int'(col_cnt), 0);
      chk("t5_row", int'(row_cnt), 0);
      @(posedge clock);
      #1 rst_n = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      send_line(IMG_W, 1'b0, 0, 1'b0, fall);
      chk("t5_err_cnt", err_cnt, 1);
      start_frame();
      for (int r = 0; r < IMG_H; r++) send_line(IMG_W, 1'b0, r, 1'b1, fall);
      chk("t5_done_cnt", done_cnt, 5);
      chk("t5_err_after", err_cnt, 1);

      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
